// File: rtl/mux_nxw_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_nxw_stream_if
// Description : Request / output-stream bundle for mux_nxw_stream. The
//               "slave" modport is the streaming block itself; "master" is
//               the environment that issues requests and consumes beats.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_nxw_stream_if #(
  parameter int NUM_IN = 40,
  parameter int WIDTH  = 64,
  parameter int SEL_W  = 6,
  parameter int CNT_W  = 6
);
  logic                    req_valid;
  logic                    req_ready;
  logic [NUM_IN*WIDTH-1:0] req_data;
  logic [SEL_W-1:0]        req_start;
  logic [CNT_W-1:0]        req_count;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_index;
  logic                    out_last;
  logic                    out_err;
  logic                    busy;

  modport master (
    output req_valid, req_data, req_start, req_count, out_ready,
    input  req_ready, out_valid, out_data, out_index, out_last, out_err, busy
  );

  modport slave (
    input  req_valid, req_data, req_start, req_count, out_ready,
    output req_ready, out_valid, out_data, out_index, out_last, out_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_nxw_stream.sv
`default_nettype none
// ============================================================================
// Module      : mux_nxw_stream
// Description : Snapshots an NUM_IN x WIDTH packed vector on request, then
//               streams count+1 consecutive entries (wrapping modulo NUM_IN)
//               over a valid/ready output with backpressure. An out-of-range
//               start index produces a single zero-data error beat.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nxw_stream #(
  parameter int NUM_IN = 40,
  parameter int WIDTH  = 64,
  parameter int SEL_W  = 6,
  parameter int CNT_W  = 6
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  mux_nxw_stream_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // One extra bit so the range check stays correct even when NUM_IN == 2**SEL_W.
  localparam logic [SEL_W:0]   c_num_in_ext = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] c_last_idx   = SEL_W'(NUM_IN - 1);

  state_t                  r_state;
  logic [NUM_IN*WIDTH-1:0] r_snap;
  logic [WIDTH-1:0]        r_data;
  logic [SEL_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_rem;
  logic                    r_last;
  logic                    r_err;

  logic [WIDTH-1:0]        w_snap_ent [NUM_IN];
  logic [WIDTH-1:0]        w_req_ent  [NUM_IN];
  logic                    w_start_err;
  logic [SEL_W-1:0]        w_idx_inc;

  // Array views of the live request vector and the captured snapshot.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_entries
      assign w_snap_ent[gi] = r_snap[gi*WIDTH +: WIDTH];
      assign w_req_ent[gi]  = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_start_err = ({1'b0, bus.req_start} >= c_num_in_ext);
  assign w_idx_inc   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

  // Control FSM: all beat fields are registered so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_snap  <= bus.req_data;
            r_idx   <= bus.req_start;
            r_rem   <= bus.req_count;
            r_err   <= w_start_err;
            r_last  <= w_start_err || (bus.req_count == '0);
            // First beat is preloaded from the live vector so it appears
            // the cycle right after acceptance.
            r_data  <= w_start_err ? '0 : w_req_ent[bus.req_start];
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (bus.out_ready) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_err   <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
            end else begin
              // Error runs are always last, so the index here is in range.
              r_idx  <= w_idx_inc;
              r_rem  <= r_rem - 1'b1;
              r_last <= (r_rem == CNT_W'(1));
              r_data <= w_snap_ent[w_idx_inc];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_STREAM);
  assign bus.out_valid = (r_state == ST_STREAM);
  assign bus.out_data  = r_data;
  assign bus.out_index = r_idx;
  assign bus.out_last  = r_last;
  assign bus.out_err   = r_err;

endmodule
`default_nettype wire
